// File: rtl/scan_reg_bank.sv
// Parallel scan-chain register bank with functional capture, shift-length tracking and an
// optional 16-bit MISR over the scan-out bits (enabled by defining SCAN_REG_BANK_MISR_EN).
module scan_reg_bank #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned CHAINS = 4
) (
    input  logic                    CK,
    input  logic                    RST,
    input  logic                    test_se,
    input  logic [CHAINS-1:0]       test_si,
    output logic [CHAINS-1:0]       test_so,
    input  logic [CHAINS*WIDTH-1:0] D,
    input  logic                    ENB,
    output logic [CHAINS*WIDTH-1:0] Q,
    output logic                    shift_done,
    output logic [15:0]             signature
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    logic [CHAINS*WIDTH-1:0] q_q;
    logic [CHAINS*WIDTH-1:0] shifted;
    logic [CntW-1:0]         cnt_q;
    logic                    done_q;

    // Each chain moves toward its MSB; bit 0 takes that chain's scan-in.
    always_comb begin
        shifted = '0;
        for (int unsigned c = 0; c < CHAINS; c++) begin
            shifted[c*WIDTH] = test_si[c];
            for (int unsigned i = 1; i < WIDTH; i++) begin
                shifted[c*WIDTH+i] = q_q[c*WIDTH+i-1];
            end
        end
    end

    always_comb begin
        test_so = '0;
        for (int unsigned c = 0; c < CHAINS; c++) begin
            test_so[c] = q_q[c*WIDTH+WIDTH-1];
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (test_se) begin
            q_q <= shifted;
            if (cnt_q == CntMax) begin
                cnt_q  <= '0;
                done_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
                done_q <= 1'b0;
            end
        end else begin
            if (!ENB) begin
                q_q <= D;
            end
            // Any functional cycle discards a partial shift.
            cnt_q  <= '0;
            done_q <= 1'b0;
        end
    end

    assign Q          = q_q;
    assign shift_done = done_q;

`ifdef SCAN_REG_BANK_MISR_EN
    logic [15:0] sig_q;
    logic [15:0] sig_d;
    logic [15:0] so_ext;

    // Galois-style step with polynomial x^16+x^12+x^5+1, then fold in this cycle's scan-out.
    always_comb begin
        so_ext              = '0;
        so_ext[CHAINS-1:0]  = test_so;
        sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ so_ext;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            sig_q <= '0;
        end else if (test_se) begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_scan_reg_bank.sv
// Directed self-checking bench for scan_reg_bank at WIDTH=4, CHAINS=2.
module tb_scan_reg_bank;

    logic        ck;
    logic        rst;
    logic        se;
    logic [1:0]  si;
    logic [1:0]  so;
    logic [7:0]  d;
    logic        enb;
    logic [7:0]  q;
    logic        sd;
    logic [15:0] sig;

    integer total;
    integer bad;

    scan_reg_bank #(
        .WIDTH  (4),
        .CHAINS (2)
    ) dut (
        .CK         (ck),
        .RST        (rst),
        .test_se    (se),
        .test_si    (si),
        .test_so    (so),
        .D          (d),
        .ENB        (enb),
        .Q          (q),
        .shift_done (sd),
        .signature  (sig)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    task automatic test_reset;
        se = 1'b0; enb = 1'b0; d = 8'hFF;
        tick;
        total++;
        if (q !== 8'hFF) begin bad++; $display("FAIL preload q got %h want ff", q); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++;
        if (q !== 8'h00) begin bad++; $display("FAIL reset q got %h want 00", q); end
        total++;
        if (sd !== 1'b0) begin bad++; $display("FAIL reset shift_done got %b want 0", sd); end
        total++;
        if (sig !== 16'h0000) begin bad++; $display("FAIL reset sig got %h want 0000", sig); end
    endtask

    task automatic test_capture_hold;
        se = 1'b0; enb = 1'b0; d = 8'hA5;
        tick;
        total++;
        if (q !== 8'hA5) begin bad++; $display("FAIL capture q got %h want a5", q); end
        enb = 1'b1; d = 8'h3C;
        tick;
        total++;
        if (q !== 8'hA5) begin bad++; $display("FAIL hold q got %h want a5", q); end
        tick;
        total++;
        if (q !== 8'hA5) begin bad++; $display("FAIL hold2 q got %h want a5", q); end
    endtask

    task automatic test_full_shift;
        logic [3:0] s0;
        logic [3:0] s1;
        s0 = 4'b1010;
        s1 = 4'b0101;
        se = 1'b1; si = 2'b00; enb = 1'b0; d = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (so !== {s1[k], s0[k]}) begin
                bad++; $display("FAIL shift so[%0d] got %b want %b", k, so, {s1[k], s0[k]});
            end
            tick;
            total++;
            if (sd !== (k == 3)) begin
                bad++; $display("FAIL shift done[%0d] got %b want %b", k, sd, (k == 3));
            end
        end
        total++;
        if (q !== 8'h00) begin bad++; $display("FAIL shift q got %h want 00", q); end
        se = 1'b0; enb = 1'b1;
        tick;
        total++;
        if (sd !== 1'b0) begin bad++; $display("FAIL shift pulse width got %b want 0", sd); end
    endtask

    task automatic test_aborted_shift;
        se = 1'b1; si = 2'b11; enb = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick;
            total++;
            if (sd !== 1'b0) begin bad++; $display("FAIL abort burst1[%0d] got %b want 0", k, sd); end
        end
        se = 1'b0;
        tick;
        total++;
        if (sd !== 1'b0) begin bad++; $display("FAIL abort gap got %b want 0", sd); end
        se = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            total++;
            if (sd !== (k == 3)) begin
                bad++; $display("FAIL abort burst2[%0d] got %b want %b", k, sd, (k == 3));
            end
        end
        total++;
        if (q !== 8'hFF) begin bad++; $display("FAIL abort q got %h want ff", q); end
        se = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        se = 1'b1; si = 2'b00; enb = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick;
            total++;
            if (sd !== ((k % 4) == 3)) begin
                bad++; $display("FAIL b2b done[%0d] got %b want %b", k, sd, ((k % 4) == 3));
            end
        end
        se = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_shift;
        se = 1'b0; enb = 1'b0; d = 8'hFF;
        tick;
        se = 1'b1; si = 2'b00;
        tick;
        total++;
        if (q !== 8'hEE) begin bad++; $display("FAIL midrst shift1 q got %h want ee", q); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++;
        if (q !== 8'h00) begin bad++; $display("FAIL midrst q got %h want 00", q); end
        total++;
        if (sd !== 1'b0) begin bad++; $display("FAIL midrst done got %b want 0", sd); end
        for (int k = 0; k < 4; k++) begin
            tick;
            total++;
            if (sd !== (k == 3)) begin
                bad++; $display("FAIL midrst restart[%0d] got %b want %b", k, sd, (k == 3));
            end
        end
        se = 1'b0;
        tick;
    endtask

    task automatic test_misr;
        logic [15:0] e1;
        logic [15:0] e2;
`ifdef SCAN_REG_BANK_MISR_EN
        e1 = 16'h0003;
        e2 = 16'h0006;
`else
        e1 = 16'h0000;
        e2 = 16'h0000;
`endif
        rst = 1'b1;
        tick;
        rst = 1'b0;
        se = 1'b0; enb = 1'b0; d = 8'h88;
        tick;
        total++;
        if (so !== 2'b11) begin bad++; $display("FAIL misr so got %b want 11", so); end
        total++;
        if (sig !== 16'h0000) begin bad++; $display("FAIL misr capture sig got %h want 0000", sig); end
        se = 1'b1; si = 2'b01;
        tick;
        total++;
        if (sig !== e1) begin bad++; $display("FAIL misr step1 got %h want %h", sig, e1); end
        total++;
        if (q !== 8'h01) begin bad++; $display("FAIL misr q got %h want 01", q); end
        si = 2'b00;
        tick;
        total++;
        if (sig !== e2) begin bad++; $display("FAIL misr step2 got %h want %h", sig, e2); end
        se = 1'b0; enb = 1'b1;
        tick;
        total++;
        if (sig !== e2) begin bad++; $display("FAIL misr hold got %h want %h", sig, e2); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++;
        if (sig !== 16'h0000) begin bad++; $display("FAIL misr clear got %h want 0000", sig); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; se = 1'b0; si = 2'b00; d = 8'h00; enb = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        test_reset;
        test_capture_hold;
        test_full_shift;
        test_aborted_shift;
        test_back_to_back;
        test_reset_mid_shift;
        test_misr;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
